// File: rtl/joy_scan_sequencer_if.sv
// ==== joy_scan_sequencer_if : pin/bus bundle for the joystick scan sequencer -- rev 1.0 ====
`default_nettype none

interface joy_scan_sequencer_if;
  logic       scan_en;
  logic       joy_data;
  logic       joy_clk;
  logic       joy_load;
  logic       joy_select;
  logic [7:0] joystick1;
  logic [7:0] joystick2;
  logic [7:0] joystick1_ext;
  logic [7:0] joystick2_ext;
  logic       frame_valid;
  logic       busy;

  modport master (
    input  scan_en, joy_data,
    output joy_clk, joy_load, joy_select, joystick1, joystick2,
           joystick1_ext, joystick2_ext, frame_valid, busy
  );

  modport slave (
    output scan_en, joy_data,
    input  joy_clk, joy_load, joy_select, joystick1, joystick2,
           joystick1_ext, joystick2_ext, frame_valid, busy
  );
endinterface

`default_nettype wire

// File: rtl/joy_scan_sequencer.sv
// ==== joy_scan_sequencer : DB9 serial joystick scan/framing sequencer, optional JOY_MD6_EN -- rev 1.0 ====
`default_nettype none

module joy_scan_sequencer #(
  parameter int CLK_DIV  = 8,
  parameter int GAP_BITS = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  joy_scan_sequencer_if.master  jif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * GAP_BITS + 1);
  localparam int CW = (HW > 5) ? HW : 5;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            jclk_q, jclk_d;
  logic            load_q, load_d;
  logic [15:0]     shift_q, shift_d;
  logic            fv_q, fv_d;
  logic [7:0]      j1_q, j1_d, j2_q, j2_d;
  logic            w_half;
  logic            w_commit;
`ifdef JOY_MD6_EN
  logic [7:0]      e1_q, e1_d, e2_q, e2_d;
  logic            sel_q, sel_d;
  logic            first_q, first_d;
`endif

  // Chain delivers buttons active-low in order start,f3,f2,f1,right,left,down,up.
  function automatic logic [7:0] f_word(input logic [7:0] s);
    return ~{s[0], s[1], s[2], s[3], s[7], s[6], s[5], s[4]};
  endfunction

  assign w_half = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    state_d  = state_q;
    div_d    = w_half ? '0 : div_q + DW'(1);
    cnt_d    = cnt_q;
    jclk_d   = 1'b0;
    shift_d  = shift_q;
    fv_d     = 1'b0;
    j1_d     = j1_q;
    j2_d     = j2_q;
    w_commit = 1'b0;
`ifdef JOY_MD6_EN
    e1_d     = e1_q;
    e2_d     = e2_q;
    sel_d    = sel_q;
    first_d  = first_q;
`endif

    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (jif.scan_en) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (w_half) begin
          if (cnt_q == CW'(1)) state_d = S_SHIFT;
          else                 cnt_d   = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        jclk_d = jclk_q;
        if (w_half) begin
          jclk_d = ~jclk_q;
          if (!jclk_q) begin
            shift_d[cnt_q[3:0]] = jif.joy_data;
            cnt_d               = cnt_q + CW'(1);
          end else if (cnt_q == CW'(16)) begin
            state_d  = S_GAP;
            jclk_d   = 1'b0;
            w_commit = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (w_half) begin
          if (cnt_q == CW'(2 * GAP_BITS - 1)) state_d = jif.scan_en ? S_LOAD : S_IDLE;
          else                                cnt_d   = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every state starts with a fresh divider and counter.
    if (state_d != state_q) begin
      div_d = '0;
      cnt_d = '0;
    end

    load_d = (state_d != S_LOAD);

    if (w_commit) begin
      fv_d = 1'b1;
`ifdef JOY_MD6_EN
      if (sel_q) begin
        j1_d = f_word(shift_q[7:0]);
        j2_d = f_word(shift_q[15:8]);
      end else begin
        e1_d = f_word(shift_q[7:0]);
        e2_d = f_word(shift_q[15:8]);
      end
`else
      j1_d = f_word(shift_q[7:0]);
      j2_d = f_word(shift_q[15:8]);
`endif
    end

`ifdef JOY_MD6_EN
    // The first frame after reset keeps select high; later frames alternate.
    if (state_d == S_LOAD && state_q != S_LOAD) begin
      if (first_q) sel_d = ~sel_q;
      first_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      jclk_q  <= 1'b0;
      load_q  <= 1'b1;
      shift_q <= '0;
      fv_q    <= 1'b0;
      j1_q    <= '0;
      j2_q    <= '0;
`ifdef JOY_MD6_EN
      e1_q    <= '0;
      e2_q    <= '0;
      sel_q   <= 1'b1;
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      jclk_q  <= jclk_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      fv_q    <= fv_d;
      j1_q    <= j1_d;
      j2_q    <= j2_d;
`ifdef JOY_MD6_EN
      e1_q    <= e1_d;
      e2_q    <= e2_d;
      sel_q   <= sel_d;
      first_q <= first_d;
`endif
    end
  end

  assign jif.joy_clk     = jclk_q;
  assign jif.joy_load    = load_q;
  assign jif.joystick1   = j1_q;
  assign jif.joystick2   = j2_q;
  assign jif.frame_valid = fv_q;
  assign jif.busy        = (state_q != S_IDLE);
`ifdef JOY_MD6_EN
  assign jif.joy_select    = sel_q;
  assign jif.joystick1_ext = e1_q;
  assign jif.joystick2_ext = e2_q;
`else
  assign jif.joy_select    = 1'b1;
  assign jif.joystick1_ext = '0;
  assign jif.joystick2_ext = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_joy_scan_sequencer.sv
// ==== tb_joy_scan_sequencer : scoreboard bench for joy_scan_sequencer -- rev 1.0 ====
`default_nettype none

module tb_joy_scan_sequencer;

  localparam int FRAME  = 336;
  localparam int FV_LAT = 272;
`ifdef JOY_MD6_EN
  localparam bit MD6 = 1'b1;
`else
  localparam bit MD6 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  joy_scan_sequencer_if jif();

  joy_scan_sequencer #(.CLK_DIV(8), .GAP_BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .jif (jif)
  );

  typedef struct {
    bit         sel;
    logic [7:0] w1;
    logic [7:0] w2;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] forced_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          frames_since_rst = 0;
  int          fv_total = 0;
  int          load_starts = 0;
  int          rises = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Pad word built from named buttons; samples are active-low.
  function automatic logic [7:0] pad_word(input logic [7:0] s);
    logic start, f3, f2, f1, right, left, down, up;
    start = !s[0]; f3 = !s[1]; f2 = !s[2]; f1 = !s[3];
    right = !s[4]; left = !s[5]; down = !s[6]; up = !s[7];
    return {start, f3, f2, f1, up, down, left, right};
  endfunction

  // Splitter chain: latches a pad snapshot on load, shifts on each joy_clk fall.
  initial begin : chain_model
    logic [15:0] pat;
    int          idx;
    exp_t        e;
    pat = 16'hFFFF;
    idx = 0;
    jif.joy_data = 1'b1;
    forever begin
      @(negedge jif.joy_load or negedge jif.joy_clk);
      if (rst) continue;
      if (jif.joy_load == 1'b0) begin
        pat   = (forced_q.size() > 0) ? forced_q.pop_front() : 16'($urandom);
        idx   = 0;
        e.sel = MD6 ? (frames_since_rst % 2 == 0) : 1'b1;
        e.w1  = pad_word(pat[7:0]);
        e.w2  = pad_word(pat[15:8]);
        exp_q.push_back(e);
        frames_since_rst++;
      end else begin
        idx++;
      end
      jif.joy_data = (idx < 16) ? pat[idx] : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every frame_valid and checks framing/holding.
  int   cyc = 0;
  int   load_cyc = 0;
  int   ld_low = 0;
  int   last_fv_cyc = 0;
  bit   run_cont = 0;
  logic prev_load = 1'b1, prev_jclk = 1'b0, prev_fv = 1'b0;
  logic [7:0] m_j1 = '0, m_j2 = '0, m_e1 = '0, m_e2 = '0;

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst) begin
      m_j1 = '0; m_j2 = '0; m_e1 = '0; m_e2 = '0;
      run_cont = 0;
      ld_low = 0;
      rises = 0;
    end else begin
      if (prev_load && !jif.joy_load) begin
        load_starts++;
        load_cyc = cyc;
        ld_low = 0;
        rises = 0;
        if (exp_q.size() > 0) check("joy_select", jif.joy_select, exp_q[$].sel);
      end
      if (!jif.joy_load) ld_low++;
      if (!prev_jclk && jif.joy_clk) rises++;
      if (jif.frame_valid) begin
        fv_total++;
        check("fv_one_clk", prev_fv, 1'b0);
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          if (e.sel) begin m_j1 = e.w1; m_j2 = e.w2; end
          else       begin m_e1 = e.w1; m_e2 = e.w2; end
        end
        check("fv_latency", cyc - load_cyc, FV_LAT);
        check("load_low_clks", ld_low, 16);
        check("joy_clk_rises", rises, 16);
        if (run_cont) check("frame_period", cyc - last_fv_cyc, FRAME);
        last_fv_cyc = cyc;
        run_cont = 1;
      end
      if (!jif.busy) begin
        run_cont = 0;
        check("idle_pins", {jif.joy_load, jif.joy_clk}, 2'b10);
      end
      check("joystick1", jif.joystick1, m_j1);
      check("joystick2", jif.joystick2, m_j2);
      check("joystick1_ext", jif.joystick1_ext, m_e1);
      check("joystick2_ext", jif.joystick2_ext, m_e2);
    end
    prev_load = jif.joy_load;
    prev_jclk = jif.joy_clk;
    prev_fv   = jif.frame_valid;
  end

  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    frames_since_rst = 0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_fv(input int n, input string tag);
    int target, k;
    target = fv_total + n;
    k = 0;
    while (fv_total < target && k < n * FRAME + 1000) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_fv_seen"}, (fv_total >= target), 1'b1);
  endtask

  task automatic wait_shift_bit(input int n, input string tag);
    int s0, k;
    s0 = load_starts;
    k = 0;
    while (load_starts == s0 && k < 2 * FRAME) begin @(negedge clk); k++; end
    while (rises < n && k < 3 * FRAME) begin @(negedge clk); k++; end
    check({tag, "_reached"}, (load_starts != s0 && rises >= n), 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (jif.busy && k < 2 * FRAME) begin @(negedge clk); k++; end
    check({tag, "_idle"}, jif.busy, 1'b0);
  endtask

  initial begin : stimulus
    int fv0, ls0;
    jif.scan_en = 1'b0;

    // Reset state
    apply_reset(2);
    repeat (3) @(negedge clk);
    check("rst_joy_load", jif.joy_load, 1'b1);
    check("rst_joy_clk", jif.joy_clk, 1'b0);
    check("rst_joy_select", jif.joy_select, 1'b1);
    check("rst_words", {jif.joystick1, jif.joystick2, jif.joystick1_ext, jif.joystick2_ext}, 32'h0);
    check("rst_fv", jif.frame_valid, 1'b0);
    check("rst_busy", jif.busy, 1'b0);

    // Directed frame: samples 7 (up1) and 8 (start2) pressed
    forced_q.push_back(16'hFE7F);
    @(posedge clk); #1 jif.scan_en = 1'b1;
    @(negedge clk);
    check("load_not_yet", jif.joy_load, 1'b1);
    @(negedge clk);
    check("load_after_1clk", jif.joy_load, 1'b0);
    wait_fv(1, "directed");
    check("directed_j1", jif.joystick1, 8'h08);
    check("directed_j2", jif.joystick2, 8'h80);

    // Continuous random frames
    wait_fv(8, "continuous");

    // Drop scan_en mid-shift: the frame still commits, then idle
    wait_shift_bit(5, "drop");
    @(posedge clk); #1 jif.scan_en = 1'b0;
    fv0 = fv_total;
    wait_idle("drop");
    check("drop_commits_once", fv_total - fv0, 1);
    ls0 = load_starts;
    repeat (1000) @(negedge clk);
    check("drop_no_more_loads", load_starts - ls0, 0);
    check("drop_still_idle", jif.busy, 1'b0);

    // Reset mid-shift aborts the frame and clears the words
    forced_q.push_back(16'hFE7F);
    @(posedge clk); #1 jif.scan_en = 1'b1;
    wait_fv(1, "pre_rst");
    check("pre_rst_j1", jif.joystick1, 8'h08);
    wait_shift_bit(10, "rst_mid");
    fv0 = fv_total;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    frames_since_rst = 0;
    jif.scan_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_words", {jif.joystick1, jif.joystick2}, 16'h0);
    check("midrst_fv", jif.frame_valid, 1'b0);
    check("midrst_busy", jif.busy, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_no_commit", fv_total - fv0, 0);
    check("midrst_idle", jif.busy, 1'b0);

    // Released buttons on the first frame, all pressed on the second
    forced_q.push_back(16'hFFFF);
    forced_q.push_back(16'h0000);
    @(posedge clk); #1 jif.scan_en = 1'b1;
    wait_fv(2, "pair");
`ifdef JOY_MD6_EN
    check("md6_j1", jif.joystick1, 8'h00);
    check("md6_j1_ext", jif.joystick1_ext, 8'hFF);
`else
    check("pair_j1", jif.joystick1, 8'hFF);
    check("pair_j1_ext", jif.joystick1_ext, 8'h00);
`endif
    wait_fv(4, "tail");
    jif.scan_en = 1'b0;
    wait_idle("tail");
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #(10 * 90000);
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
